// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB management-instruction sequencer:
// op encodings, FSM states and the 78-bit TLB entry layout.
package tlb_pkg;

    // CP0 TLB instruction encodings as presented on op_type
    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_t;

    // Sequencer states; every op visits exactly one working state then DONE
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } tlb_state_t;

    localparam int TLB_ENTRY_W = 78;

    // Field widths inside a TLB entry
    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;
    localparam int C_W    = 3;

    // Field offsets, MSB to LSB: vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1
    localparam int V1_BIT   = 0;
    localparam int D1_BIT   = 1;
    localparam int C1_LSB   = 2;
    localparam int PFN1_LSB = 5;
    localparam int V0_BIT   = 25;
    localparam int D0_BIT   = 26;
    localparam int C0_LSB   = 27;
    localparam int PFN0_LSB = 30;
    localparam int G_BIT    = 50;
    localparam int ASID_LSB = 51;
    localparam int VPN2_LSB = 59;

endpackage

// File: rtl/tlb_entry_codec.sv
// Combinational conversion between the CP0 EntryHi/EntryLo0/EntryLo1 view
// and the packed 78-bit TLB entry, in both directions.
module tlb_entry_codec
    import tlb_pkg::*;
(
    input  logic [31:0]            entryhi_i,
    input  logic [31:0]            entrylo0_i,
    input  logic [31:0]            entrylo1_i,
    output logic [TLB_ENTRY_W-1:0] entry_o,
    input  logic [TLB_ENTRY_W-1:0] entry_i,
    output logic [31:0]            entryhi_o,
    output logic [31:0]            entrylo0_o,
    output logic [31:0]            entrylo1_o
);

    // EntryHi[12:8] and EntryLoX[31:26] have no home in a TLB entry
    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

    // Pack: the global bit is only set when both halves agree it is global
    always_comb begin
        entry_o = {
            entryhi_i[31:13],
            entryhi_i[7:0],
            entrylo0_i[0] & entrylo1_i[0],
            entrylo0_i[25:6], entrylo0_i[5:3], entrylo0_i[2], entrylo0_i[1],
            entrylo1_i[25:6], entrylo1_i[5:3], entrylo1_i[2], entrylo1_i[1]
        };
    end

    // Unpack: the single g bit is replicated into bit 0 of both EntryLo words
    always_comb begin
        entryhi_o  = {entry_i[VPN2_LSB +: VPN2_W], 5'b0, entry_i[ASID_LSB +: ASID_W]};
        entrylo0_o = {6'b0, entry_i[PFN0_LSB +: PFN_W], entry_i[C0_LSB +: C_W],
                      entry_i[D0_BIT], entry_i[V0_BIT], entry_i[G_BIT]};
        entrylo1_o = {6'b0, entry_i[PFN1_LSB +: PFN_W], entry_i[C1_LSB +: C_W],
                      entry_i[D1_BIT], entry_i[V1_BIT], entry_i[G_BIT]};
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer. Captures the CP0 operands on accept,
// spends one cycle on the TLB port the op needs, and commits in DONE.
// Every op takes 3 cycles; a flush or reset drops the op with no writes.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    input  logic [1:0]             op_type,
    input  logic                   exc_flush,
    output logic                   op_ready,
    output logic                   stall,
    output logic                   done,
    input  logic [31:0]            entryhi_in,
    input  logic [31:0]            entrylo0_in,
    input  logic [31:0]            entrylo1_in,
    input  logic [31:0]            index_in,
    input  logic [31:0]            random_in,
    output logic [VPN2_W-1:0]      s1_vpn2,
    output logic [ASID_W-1:0]      s1_asid,
    input  logic                   s1_found,
    input  logic [IDX_W-1:0]       s1_index,
    output logic [IDX_W-1:0]       r_index,
    input  logic [TLB_ENTRY_W-1:0] r_entry,
    output logic                   we,
    output logic [IDX_W-1:0]       w_index,
    output logic [TLB_ENTRY_W-1:0] w_entry,
    output logic                   index_wren,
    output logic                   found_out,
    output logic [31:0]            index_wdata,
    output logic                   entryhi_wren,
    output logic                   entrylo0_wren,
    output logic                   entrylo1_wren,
    output logic [31:0]            entryhi_wdata,
    output logic [31:0]            entrylo0_wdata,
    output logic [31:0]            entrylo1_wdata
);

    // Index arithmetic wraps inside the TLB; TLBNUM is a power of two
    localparam logic [31:0] IDX_MASK = 32'(TLBNUM - 1);

    tlb_state_t       state_q;
    tlb_op_t          op_q;
    logic [31:0]      entryhi_q;
    logic [31:0]      entrylo0_q;
    logic [31:0]      entrylo1_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] hit_index_q;
    logic             found_q;

    logic accept;
    logic live;

    // Only the low IDX_W bits of Index/Random select an entry
    logic unused_bits;
    assign unused_bits = ^{index_in[31:IDX_W], random_in[31:IDX_W]};

    assign accept = op_valid && (state_q == S_IDLE) && !exc_flush;
    // Side effects are suppressed in the very cycle a flush or reset arrives
    assign live   = !exc_flush && !rst;

    // Sequencer FSM: capture operands on accept, then one working cycle and DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_TLBP;
            entryhi_q   <= '0;
            entrylo0_q  <= '0;
            entrylo1_q  <= '0;
            index_q     <= '0;
            random_q    <= '0;
            hit_index_q <= '0;
            found_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= tlb_op_t'(op_type);
                        entryhi_q  <= entryhi_in;
                        entrylo0_q <= entrylo0_in;
                        entrylo1_q <= entrylo1_in;
                        index_q    <= index_in[IDX_W-1:0] & IDX_MASK[IDX_W-1:0];
                        random_q   <= random_in[IDX_W-1:0] & IDX_MASK[IDX_W-1:0];
                        case (tlb_op_t'(op_type))
                            OP_TLBP: state_q <= S_SEARCH;
                            OP_TLBR: state_q <= S_READ;
                            default: state_q <= S_WRITE;
                        endcase
                    end
                end
                S_SEARCH: begin
                    if (exc_flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        found_q     <= s1_found;
                        hit_index_q <= s1_index;
                        state_q     <= S_DONE;
                    end
                end
                S_READ, S_WRITE: begin
                    state_q <= exc_flush ? S_IDLE : S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    tlb_entry_codec u_codec (
        .entryhi_i  (entryhi_q),
        .entrylo0_i (entrylo0_q),
        .entrylo1_i (entrylo1_q),
        .entry_o    (w_entry),
        .entry_i    (r_entry),
        .entryhi_o  (entryhi_wdata),
        .entrylo0_o (entrylo0_wdata),
        .entrylo1_o (entrylo1_wdata)
    );

    // Handshake, TLB port and CP0 commit strobes decoded from the current state
    always_comb begin
        op_ready      = (state_q == S_IDLE);
        stall         = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                        ((state_q == S_IDLE) && op_valid && !exc_flush);
        done          = (state_q == S_DONE) && live;
        s1_vpn2       = entryhi_q[31:13];
        s1_asid       = entryhi_q[7:0];
        r_index       = index_q;
        we            = (state_q == S_WRITE) && live;
        w_index       = (op_q == OP_TLBWR) ? random_q : index_q;
        index_wren    = done && (op_q == OP_TLBP);
        entryhi_wren  = done && (op_q == OP_TLBR);
        entrylo0_wren = done && (op_q == OP_TLBR);
        entrylo1_wren = done && (op_q == OP_TLBR);
        found_out     = found_q;
        index_wdata   = {{(32-IDX_W){1'b0}}, hit_index_q};
    end

endmodule
